// File: rtl/prince_share_recombiner.sv
// Output-side share recombiner for the 3-share PRINCE datapath: unmasks one nibble
// per accept through a register-split XOR and releases 16-nibble words over valid/ready.
module prince_share_recombiner #(
  parameter int NIB_W   = 4,
  parameter int NUM_NIB = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W-1:0]         in_sh0,
  input  logic [NIB_W-1:0]         in_sh1,
  input  logic [NIB_W-1:0]         in_sh2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NUM_NIB-1:0] out_data,
  output logic                     busy
);

  localparam int CW = $clog2(NUM_NIB + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_NIB);
  localparam logic [CW-1:0] LAST = CW'(NUM_NIB - 1);

  typedef enum logic {
    COLLECT,
    OUTPUT
  } state_t;

  state_t                          state;
  logic [CW-1:0]                   acc_cnt;
  logic [CW-1:0]                   wr_cnt;
  logic [NIB_W-1:0]                s1_a;
  logic [NIB_W-1:0]                s1_c;
  logic                            s1_v;
  logic [NUM_NIB-1:0][NIB_W-1:0]   asm_reg;
  logic                            accept;

  assign in_ready  = (state == COLLECT) && (acc_cnt < FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == OUTPUT);
  assign busy      = (acc_cnt != '0) || (state == OUTPUT);
  // A half-built word must never leak, so the bus reads zero outside OUTPUT.
  assign out_data  = out_valid ? asm_reg : '0;

  // Share 2 is only combined after a register stage, so no cone sees all three shares.
  // s1_a/s1_c deliberately hold their last values; s1_v alone qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      s1_a    <= '0;
      s1_c    <= '0;
      s1_v    <= 1'b0;
      asm_reg <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_a    <= in_sh0 ^ in_sh1;
        s1_c    <= in_sh2;
        acc_cnt <= acc_cnt + CW'(1);
      end
      case (state)
        COLLECT: begin
          if (s1_v) begin
            for (int k = 0; k < NUM_NIB; k++) begin
              if (wr_cnt == CW'(k)) asm_reg[k] <= s1_a ^ s1_c;
            end
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_cnt == LAST) state <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state   <= COLLECT;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            asm_reg <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_prince_share_recombiner.sv
// Directed bench for prince_share_recombiner: drives on the falling edge,
// samples on the falling edge, expected words are hand-chosen constants.
module tb_prince_share_recombiner;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 16;
  localparam int W       = NIB_W * NUM_NIB;

  localparam logic [W-1:0] WORD_SEQ = 64'hFEDCBA9876543210;
  localparam logic [W-1:0] WORD_P1  = 64'h0123456789ABCDEF;
  localparam logic [W-1:0] WORD_P3  = 64'hCAFEBABEDEADBEEF;
  localparam logic [W-1:0] WORD_P5  = 64'h13579BDF02468ACE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NIB_W-1:0] in_sh0 = '0;
  logic [NIB_W-1:0] in_sh1 = '0;
  logic [NIB_W-1:0] in_sh2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic             busy;

  int total = 0;
  int bad   = 0;

  prince_share_recombiner #(.NIB_W(NIB_W), .NUM_NIB(NUM_NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sh0    (in_sh0),
    .in_sh1    (in_sh1),
    .in_sh2    (in_sh2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds one nibble on the bus until it is taken, bounded by a retry budget.
  task automatic applyStimulus(input logic [NIB_W-1:0] s0, input logic [NIB_W-1:0] s1,
                               input logic [NIB_W-1:0] s2);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_sh0   = s0;
    in_sh1   = s1;
    in_sh2   = s2;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("accept", W'(acc), W'(1'b1));
  endtask

  // Masked nibble k of p: sh0=p^r0, sh1=r1, sh2=r0^r1; fixed masks r0=0, r1=A otherwise.
  task automatic sendWord(input logic [W-1:0] p, input int first, input int count,
                          input int gap, input bit rnd);
    logic [NIB_W-1:0] r0;
    logic [NIB_W-1:0] r1;
    logic [NIB_W-1:0] pk;
    for (int k = first; k < first + count; k++) begin
      if (k > first) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          checkOutput("gap_busy", W'(busy), W'(1'b1));
        end
      end
      r0 = rnd ? NIB_W'($urandom_range(15, 0)) : 4'h0;
      r1 = rnd ? NIB_W'($urandom_range(15, 0)) : 4'hA;
      pk = p[NIB_W*k +: NIB_W];
      applyStimulus(pk ^ r0, r1, r0 ^ r1);
    end
  endtask

  initial begin
    #12;
    checkOutput("rst_out_valid", W'(out_valid), '0);
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_busy", W'(busy), '0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", W'(in_ready), W'(1'b1));
    checkOutput("rst_out_valid2", W'(out_valid), '0);

    // Back-to-back word with out_ready already high.
    out_ready = 1'b1;
    sendWord(WORD_SEQ, 0, 16, 0, 1'b0);
    checkOutput("b2b_ready_drop", W'(in_ready), '0);
    checkOutput("b2b_lat1_valid", W'(out_valid), '0);
    checkOutput("b2b_lat1_data", out_data, '0);
    checkOutput("b2b_busy", W'(busy), W'(1'b1));
    tick();
    checkOutput("b2b_lat2_valid", W'(out_valid), W'(1'b1));
    checkOutput("b2b_data", out_data, WORD_SEQ);
    tick();
    checkOutput("b2b_valid_drop", W'(out_valid), '0);
    checkOutput("b2b_ready_back", W'(in_ready), W'(1'b1));
    checkOutput("b2b_data_zero", out_data, '0);
    checkOutput("b2b_busy_clear", W'(busy), '0);

    // Random masking, pausing after 15 nibbles to confirm nothing is visible.
    sendWord(WORD_P1, 0, 15, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("vis_valid", W'(out_valid), '0);
      checkOutput("vis_data", out_data, '0);
      checkOutput("vis_ready", W'(in_ready), W'(1'b1));
      tick();
    end
    sendWord(WORD_P1, 15, 1, 0, 1'b1);
    checkOutput("rnd_lat1_valid", W'(out_valid), '0);
    tick();
    checkOutput("rnd_valid", W'(out_valid), W'(1'b1));
    checkOutput("rnd_data", out_data, WORD_P1);
    tick();
    checkOutput("rnd_valid_drop", W'(out_valid), '0);

    // Backpressure with ignored input pulses.
    out_ready = 1'b0;
    sendWord(WORD_P3, 0, 16, 0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", W'(out_valid), W'(1'b1));
      checkOutput("bp_data", out_data, WORD_P3);
      checkOutput("bp_ready", W'(in_ready), '0);
      in_valid = 1'b1;
      in_sh0   = NIB_W'($urandom_range(15, 0));
      in_sh1   = NIB_W'($urandom_range(15, 0));
      in_sh2   = NIB_W'($urandom_range(15, 0));
      tick();
      in_valid = 1'b0;
    end
    checkOutput("bp_data_hold", out_data, WORD_P3);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_valid_drop", W'(out_valid), '0);
    checkOutput("bp_ready_back", W'(in_ready), W'(1'b1));
    checkOutput("bp_busy_clear", W'(busy), '0);

    // Gapped input: one valid cycle then two idle ones per nibble.
    sendWord(WORD_SEQ, 0, 16, 2, 1'b0);
    checkOutput("gap_busy_end", W'(busy), W'(1'b1));
    tick();
    checkOutput("gap_valid", W'(out_valid), W'(1'b1));
    checkOutput("gap_data", out_data, WORD_SEQ);
    checkOutput("gap_busy_out", W'(busy), W'(1'b1));
    tick();
    checkOutput("gap_busy_clear", W'(busy), '0);

    // Asynchronous reset after 7 accepts discards the partial word.
    sendWord(WORD_P1, 0, 7, 0, 1'b1);
    checkOutput("mid_busy", W'(busy), W'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", W'(out_valid), '0);
    checkOutput("mid_rst_data", out_data, '0);
    checkOutput("mid_rst_busy", W'(busy), '0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rel_ready", W'(in_ready), W'(1'b1));
    sendWord(WORD_P5, 0, 16, 0, 1'b1);
    checkOutput("mid_lat1_valid", W'(out_valid), '0);
    tick();
    checkOutput("mid_valid", W'(out_valid), W'(1'b1));
    checkOutput("mid_data", out_data, WORD_P5);
    tick();
    checkOutput("mid_valid_drop", W'(out_valid), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
